// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the dual-clock FIFO write-side arbiter.
package fifo_arb_pkg;

  localparam int unsigned DEF_WIDTH     = 8;
  localparam int unsigned DEF_NUM_REQ   = 4;
  localparam int unsigned DEF_MAX_BURST = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after last_ptr, wrapping.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_ptr,
  output logic               any,
  output logic [IDX_W-1:0]   idx
);

  localparam int unsigned SUM_W = IDX_W + 1;

  logic [SUM_W-1:0] sum;
  logic [IDX_W-1:0] cand;

  // Offset k=NUM_REQ lands back on last_ptr itself, so it has lowest priority.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    sum  = '0;
    cand = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      sum = {1'b0, last_ptr} + SUM_W'(k);
      if (sum >= SUM_W'(NUM_REQ)) begin
        sum = sum - SUM_W'(NUM_REQ);
      end
      cand = sum[IDX_W-1:0];
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among packet sources;
// a grant lasts until the owner's last beat or the burst cap.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
  parameter int unsigned MAX_BURST = DEF_MAX_BURST,
  parameter int unsigned IDX_W     = $clog2(NUM_REQ)
) (
  input  logic                     wr_clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]       req_last,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     wr_full,
  output logic                     wr_en,
  output logic [WIDTH-1:0]         wr_data,
  output logic [IDX_W-1:0]         grant_id,
  output logic                     busy
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST) + 1;

  state_t           state, state_next;
  logic [IDX_W-1:0] last_ptr, last_ptr_next;
  logic [IDX_W-1:0] grant_next;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_next, beat_inc;

  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;

  logic             owner_valid;
  logic             owner_last;
  logic [WIDTH-1:0] owner_data;
  logic             xfer;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req      (req_valid),
    .last_ptr (last_ptr),
    .any      (pick_any),
    .idx      (pick_idx)
  );

  // Select the current owner's beat.
  always_comb begin
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    owner_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_id == IDX_W'(i)) begin
        owner_valid = req_valid[i];
        owner_last  = req_last[i];
        owner_data  = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign busy     = (state == ST_GRANT);
  assign beat_inc = beat_cnt + CNT_W'(1);

  // Next-state and write-port outputs; reset blocks any transfer in its cycle.
  always_comb begin
    state_next    = state;
    last_ptr_next = last_ptr;
    grant_next    = grant_id;
    beat_cnt_next = beat_cnt;
    req_ready     = '0;
    wr_en         = 1'b0;
    wr_data       = '0;
    xfer          = 1'b0;

    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          grant_next    = pick_idx;
          beat_cnt_next = '0;
          state_next    = ST_GRANT;
        end
      end

      ST_GRANT: begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          req_ready[i] = (grant_id == IDX_W'(i)) && !wr_full && !reset;
        end
        xfer = owner_valid && !wr_full && !reset;
        if (xfer) begin
          wr_en         = 1'b1;
          wr_data       = owner_data;
          beat_cnt_next = beat_inc;
          if (owner_last || (beat_inc == CNT_W'(MAX_BURST))) begin
            state_next    = ST_IDLE;
            last_ptr_next = grant_id;
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge wr_clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      last_ptr <= IDX_W'(NUM_REQ - 1);
      beat_cnt <= '0;
      grant_id <= '0;
    end else begin
      state    <= state_next;
      last_ptr <= last_ptr_next;
      beat_cnt <= beat_cnt_next;
      grant_id <= grant_next;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench: per-cycle comparison against a transaction-level arbiter model,
// directed scenarios pinned with literal write logs, then randomized traffic.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;

  logic           clk;
  logic           rst;
  logic [N-1:0]   valid, last, ready;
  logic [N*W-1:0] data;
  logic           full, wr_en;
  logic [W-1:0]   wr_data;
  logic [1:0]     gid;
  logic           busy;

  int errors = 0;
  int checks = 0;

  // Source packet queues: head is the beat currently presented.
  logic [W-1:0] sq [N][$];
  bit           sl [N][$];

  // Model: is someone granted, who, beats so far, who has top priority next.
  bit m_busy;
  int m_owner, m_cnt, m_prio;

  int cyc;
  bit rnd_valid;
  int wsrc[$], wcyc[$], wdat[$];
  int first_busy;
  bit last_busy, last_wren;
  int written, pushed;

  fifo_wr_arbiter #(.WIDTH(W), .NUM_REQ(N), .MAX_BURST(MB)) dut (
    .wr_clk    (clk),
    .reset     (rst),
    .req_valid (valid),
    .req_data  (data),
    .req_last  (last),
    .req_ready (ready),
    .wr_full   (full),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .grant_id  (gid),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int s, input logic [W-1:0] d, input bit l);
    sq[s].push_back(d);
    sl[s].push_back(l);
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (sq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_logs();
    wsrc.delete(); wcyc.delete(); wdat.delete();
    cyc = 0; first_busy = -1; written = 0;
  endtask

  // One clock cycle: drive, check against model, advance model and sources.
  task automatic step(input bit r, input bit f);
    logic [N-1:0] er;
    bit ee;
    bit n_busy;
    int n_owner, n_cnt, n_prio, s;
    rst = r; full = f;
    for (int i = 0; i < N; i++) begin
      if (sq[i].size() > 0 && (!rnd_valid || $urandom_range(3) != 0)) begin
        valid[i] = 1'b1; data[i*W +: W] = sq[i][0]; last[i] = sl[i][0];
      end else begin
        valid[i] = 1'b0; data[i*W +: W] = 8'($urandom); last[i] = 1'($urandom);
      end
    end
    #3;
    er = '0; ee = 1'b0;
    if (!r && m_busy) begin
      if (!f) er[m_owner] = 1'b1;
      ee = valid[m_owner] && !f;
    end
    chk("busy", 32'(busy), 32'(m_busy));
    if (m_busy) chk("grant_id", 32'(gid), 32'(m_owner));
    chk("req_ready", 32'(ready), 32'(er));
    chk("wr_en", 32'(wr_en), 32'(ee));
    if (ee) chk("wr_data", 32'(wr_data), 32'(data[m_owner*W +: W]));
    if (busy === 1'b1 && first_busy < 0) first_busy = cyc;
    last_busy = busy; last_wren = wr_en;
    if (wr_en === 1'b1) begin
      wsrc.push_back(int'(gid)); wcyc.push_back(cyc); wdat.push_back(int'(wr_data));
      written++;
    end
    n_busy = m_busy; n_owner = m_owner; n_cnt = m_cnt; n_prio = m_prio;
    if (r) begin
      n_busy = 1'b0; n_owner = 0; n_cnt = 0; n_prio = 0;
    end else if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        s = (m_prio + k) % N;
        if (!n_busy && valid[s]) begin n_busy = 1'b1; n_owner = s; n_cnt = 0; end
      end
    end else if (ee) begin
      n_cnt = m_cnt + 1;
      if (last[m_owner] || n_cnt == MB) begin
        n_busy = 1'b0; n_prio = (m_owner + 1) % N;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (valid[i] && ready[i] === 1'b1) begin
        void'(sq[i].pop_front()); void'(sl[i].pop_front());
      end
    end
    @(posedge clk); #1;
    m_busy = n_busy; m_owner = n_owner; m_cnt = n_cnt; m_prio = n_prio;
    cyc++;
  endtask

  task automatic drain(input int maxc, input int fa, input int fb);
    int n = 0;
    while ((!all_empty() || m_busy) && n < maxc) begin
      step(1'b0, cyc >= fa && cyc <= fb);
      n++;
    end
    chk("drain_done", 32'(all_empty() && !m_busy), 32'(1));
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic chk_w(input string nm, input int i, input int s, input int c, input int d);
    if (i < wsrc.size()) begin
      chk({nm, "_src"}, wsrc[i], s);
      chk({nm, "_cycle"}, wcyc[i], c);
      chk({nm, "_data"}, wdat[i], d);
    end else begin
      chk({nm, "_missing"}, wsrc.size(), i + 1);
    end
  endtask

  int e5s[12] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
  int e5c[12] = '{1, 2, 3, 4, 6, 7, 9, 10, 11, 12, 14, 15};
  int e5d[12] = '{'h01, 'h02, 'h03, 'h04, 'hb1, 'hb2, 'h05, 'h06, 'h07, 'h08, 'h09, 'h0a};

  initial begin
    int len;
    rst = 1'b1; full = 1'b0; valid = '0; last = '0; data = '0; rnd_valid = 1'b0;
    m_busy = 1'b0; m_owner = 0; m_cnt = 0; m_prio = 0;
    cyc = 0; first_busy = -1; written = 0; pushed = 0;
    repeat (2) @(posedge clk);
    #1;
    step(1'b1, 1'b0);
    chk("rst_grant_id", 32'(gid), 32'(0));
    step(1'b0, 1'b0);

    // Single 3-beat packet from requester 0.
    clear_logs();
    push(0, 8'h11, 1'b0); push(0, 8'h22, 1'b0); push(0, 8'h33, 1'b1);
    drain(40, -1, -1);
    chk("t1_nwrites", wsrc.size(), 3);
    chk("t1_first_busy", first_busy, 1);
    chk_w("t1_w0", 0, 0, 1, 'h11);
    chk_w("t1_w1", 1, 0, 2, 'h22);
    chk_w("t1_w2", 2, 0, 3, 'h33);

    // Requesters 1 and 3 alternating single-beat packets.
    clear_logs();
    push(1, 8'ha1, 1'b1); push(1, 8'ha2, 1'b1);
    push(3, 8'hb1, 1'b1); push(3, 8'hb2, 1'b1);
    drain(40, -1, -1);
    chk("t2_nwrites", wsrc.size(), 4);
    chk_w("t2_w0", 0, 1, 1, 'ha1);
    chk_w("t2_w1", 1, 3, 3, 'hb1);
    chk_w("t2_w2", 2, 1, 5, 'ha2);
    chk_w("t2_w3", 3, 3, 7, 'hb2);

    // Wrap: requester 3 owns, then 0 must come before 1.
    clear_logs();
    push(3, 8'hc1, 1'b0); push(3, 8'hc2, 1'b1);
    step(1'b0, 1'b0);
    push(0, 8'hd0, 1'b1); push(1, 8'hd1, 1'b1);
    drain(40, -1, -1);
    chk("t3_nwrites", wsrc.size(), 4);
    chk_w("t3_w0", 0, 3, 1, 'hc1);
    chk_w("t3_w1", 1, 3, 2, 'hc2);
    chk_w("t3_w2", 2, 0, 4, 'hd0);
    chk_w("t3_w3", 3, 1, 6, 'hd1);

    // 5-beat packet with wr_full for two cycles; burst cap of 4 splits it.
    clear_logs();
    for (int b = 0; b < 5; b++) push(2, 8'(8'h51 + b), b == 4);
    drain(40, 2, 3);
    chk("t4_nwrites", wsrc.size(), 5);
    chk_w("t4_w0", 0, 2, 1, 'h51);
    chk_w("t4_w1", 1, 2, 4, 'h52);
    chk_w("t4_w2", 2, 2, 5, 'h53);
    chk_w("t4_w3", 3, 2, 6, 'h54);
    chk_w("t4_w4", 4, 2, 8, 'h55);

    // Burst cap forces hand-off to requester 1 mid-packet.
    clear_logs();
    for (int b = 0; b < 10; b++) push(0, 8'(b + 1), b == 9);
    push(1, 8'hb1, 1'b0); push(1, 8'hb2, 1'b1);
    drain(60, -1, -1);
    chk("t5_nwrites", wsrc.size(), 12);
    for (int i = 0; i < 12; i++) chk_w("t5_w", i, e5s[i], e5c[i], e5d[i]);

    // Reset in the middle of a burst.
    clear_logs();
    for (int b = 0; b < 4; b++) push(2, 8'(8'h61 + b), b == 3);
    step(1'b0, 1'b0);
    push(1, 8'h71, 1'b1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("t6_wren_in_reset", 32'(last_wren), 32'(0));
    step(1'b0, 1'b0);
    chk("t6_busy_after_reset", 32'(last_busy), 32'(0));
    drain(40, -1, -1);
    chk("t6_nwrites", wsrc.size(), 5);
    chk_w("t6_w0", 0, 2, 1, 'h61);
    chk_w("t6_w1", 1, 1, 4, 'h71);
    chk_w("t6_w2", 2, 2, 6, 'h62);
    chk_w("t6_w3", 3, 2, 7, 'h63);
    chk_w("t6_w4", 4, 2, 8, 'h64);

    // Randomized traffic with gaps, back-pressure and occasional reset.
    clear_logs();
    pushed = 0;
    rnd_valid = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (sq[i].size() == 0 && $urandom_range(3) == 0) begin
          len = int'($urandom_range(7, 1));
          for (int b = 0; b < len; b++) push(i, 8'($urandom), b == len - 1);
          pushed += len;
        end
      end
      step($urandom_range(299) == 0, $urandom_range(4) == 0);
    end
    rnd_valid = 1'b0;
    drain(800, -1, -1);
    chk("rnd_bytes_written", written, pushed);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
